// File: rtl/ddr3_reset_seq_pkg.sv
// Shared types for the DDR3 startup reset sequencer: state encoding (also the
// debug encoding seen on state_o) and the terminal-count helper.
package ddr3_reset_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD_RST  = 3'd2,
        ST_WAIT_CKE  = 3'd3,
        ST_CAL       = 3'd4,
        ST_READY     = 3'd5,
        ST_FAILED    = 3'd6
    } state_t;

    // A cycle count of 0 behaves like 1, so its terminal count is 0 either way.
    function automatic int unsigned term_count(input int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ddr3_reset_sequencer.sv
// DDR3 startup reset sequencer: lock qualification, RESET#/CKE power-up timing and
// calibration handoff with timeout. Optional macro LOCK_LOSS_RESTART_EN enables lock-loss restart.
//
// state     | meaning
// IDLE      | one cycle after reset release
// WAIT_LOCK | counting consecutive synchronized lock cycles
// HOLD_RST  | fabric released, DDR RESET# held low
// WAIT_CKE  | RESET# high, waiting before CKE
// CAL       | CKE high, calibration requested, timeout running
// READY     | calibration done, memory usable
// FAILED    | calibration timed out (sticky until reset)
module ddr3_reset_sequencer
    import ddr3_reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RESET_HOLD_CYCLES  = 40000,
    parameter int unsigned CKE_WAIT_CYCLES    = 100000,
    parameter int unsigned CAL_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH          = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               cal_done,
    output logic               sys_reset,
    output logic               ddr_reset_n,
    output logic               ddr_cke,
    output logic               cal_start,
    output logic               ready,
    output logic               failed,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_WIDTH-1:0] LOCK_TC = CNT_WIDTH'(term_count(LOCK_STABLE_CYCLES));
    localparam logic [CNT_WIDTH-1:0] HOLD_TC = CNT_WIDTH'(term_count(RESET_HOLD_CYCLES));
    localparam logic [CNT_WIDTH-1:0] CKE_TC  = CNT_WIDTH'(term_count(CKE_WAIT_CYCLES));
    localparam logic [CNT_WIDTH-1:0] CAL_TC  = CNT_WIDTH'(term_count(CAL_TIMEOUT_CYCLES));

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 locked_s;

    logic sys_reset_q, sys_reset_d;
    logic ddr_reset_n_q, ddr_reset_n_d;
    logic ddr_cke_q, ddr_cke_d;
    logic cal_start_q, cal_start_d;
    logic ready_q, ready_d;
    logic failed_q, failed_d;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_WAIT_LOCK: begin
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_TC) begin
                    state_d = ST_HOLD_RST;
                    cnt_d   = '0;
                end
            end
            ST_HOLD_RST: begin
                if (cnt_q == HOLD_TC) begin
                    state_d = ST_WAIT_CKE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_CKE: begin
                if (cnt_q == CKE_TC) begin
                    state_d = ST_CAL;
                    cnt_d   = '0;
                end
            end
            ST_CAL: begin
                // cal_done takes priority over a coincident timeout
                if (cal_done) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else if (cnt_q == CAL_TC) begin
                    state_d = ST_FAILED;
                    cnt_d   = '0;
                end
            end
            ST_READY, ST_FAILED: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef LOCK_LOSS_RESTART_EN
        if (!locked_s && (state_q inside {ST_HOLD_RST, ST_WAIT_CKE, ST_CAL, ST_READY})) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
        end
`endif
    end

    // Outputs are a registered decode of the current state, so they follow state_o by one clock.
    always_comb begin
        sys_reset_d   = 1'b1;
        ddr_reset_n_d = 1'b0;
        ddr_cke_d     = 1'b0;
        cal_start_d   = 1'b0;
        ready_d       = 1'b0;
        failed_d      = 1'b0;
        case (state_q)
            ST_HOLD_RST: begin
                sys_reset_d = 1'b0;
            end
            ST_WAIT_CKE: begin
                sys_reset_d   = 1'b0;
                ddr_reset_n_d = 1'b1;
            end
            ST_CAL: begin
                sys_reset_d   = 1'b0;
                ddr_reset_n_d = 1'b1;
                ddr_cke_d     = 1'b1;
                cal_start_d   = 1'b1;
            end
            ST_READY: begin
                sys_reset_d   = 1'b0;
                ddr_reset_n_d = 1'b1;
                ddr_cke_d     = 1'b1;
                ready_d       = 1'b1;
            end
            ST_FAILED: begin
                sys_reset_d   = 1'b0;
                ddr_reset_n_d = 1'b1;
                failed_d      = 1'b1;
            end
            default: begin
                sys_reset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sys_reset_q   <= 1'b1;
            ddr_reset_n_q <= 1'b0;
            ddr_cke_q     <= 1'b0;
            cal_start_q   <= 1'b0;
            ready_q       <= 1'b0;
            failed_q      <= 1'b0;
        end else begin
            sys_reset_q   <= sys_reset_d;
            ddr_reset_n_q <= ddr_reset_n_d;
            ddr_cke_q     <= ddr_cke_d;
            cal_start_q   <= cal_start_d;
            ready_q       <= ready_d;
            failed_q      <= failed_d;
        end
    end

    assign sys_reset   = sys_reset_q;
    assign ddr_reset_n = ddr_reset_n_q;
    assign ddr_cke     = ddr_cke_q;
    assign cal_start   = cal_start_q;
    assign ready       = ready_q;
    assign failed      = failed_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_ddr3_reset_sequencer.sv
// Scoreboard bench for ddr3_reset_sequencer: expected output-change events (cycle, vector)
// are queued by the stimulus and popped by a negedge monitor whenever the outputs change.
module tb_ddr3_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pll_locked = 1'b1;
    logic       cal_done = 1'b0;
    logic       sys_reset, ddr_reset_n, ddr_cke, cal_start, ready, failed;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    ddr3_reset_sequencer #(
        .LOCK_STABLE_CYCLES (4),
        .RESET_HOLD_CYCLES  (8),
        .CKE_WAIT_CYCLES    (10),
        .CAL_TIMEOUT_CYCLES (20),
        .CNT_WIDTH          (20)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .cal_done    (cal_done),
        .sys_reset   (sys_reset),
        .ddr_reset_n (ddr_reset_n),
        .ddr_cke     (ddr_cke),
        .cal_start   (cal_start),
        .ready       (ready),
        .failed      (failed),
        .state_o     (state_o)
    );

    // cyc = number of clock edges since the last reset release
    int cyc = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int         c;
        logic [8:0] v;
        string      name;
    } ev_t;

    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    logic [8:0] cur_v;
    assign cur_v = {state_o, sys_reset, ddr_reset_n, ddr_cke, cal_start, ready, failed};

    function automatic logic [8:0] vec(input int st, input bit sr, input bit rn,
                                       input bit ck, input bit cs, input bit rd, input bit fl);
        logic [2:0] s;
        s = st[2:0];
        return {s, sr, rn, ck, cs, rd, fl};
    endfunction

    task automatic expect_ev(input string name, input int c, input logic [8:0] v);
        exp_q.push_back('{c, v, name});
    endtask

    // Monitor: every change in the output vector must match the next queued event.
    initial begin : monitor
        logic [8:0] prev_v;
        bit         first;
        ev_t        e;
        first  = 1'b1;
        prev_v = '0;
        forever begin
            @(negedge clk);
            if (first || cur_v !== prev_v) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change: got cyc=%0d vec=%b, required no change",
                             cyc, cur_v);
                end else begin
                    e = exp_q.pop_front();
                    if (e.c == cyc && e.v === cur_v)
                        n_pass++;
                    else
                        $display("FAIL %s: got cyc=%0d vec=%b, required cyc=%0d vec=%b",
                                 e.name, cyc, cur_v, e.c, e.v);
                end
                prev_v = cur_v;
                first  = 1'b0;
            end
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain_check(input string name);
        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL %s_missing_events: got %0d events outstanding, required 0 (next %s)",
                     name, exp_q.size(), exp_q[0].name);
    endtask

    // Asserts reset, checks the outputs fall to reset values before any clock edge, releases.
    task automatic do_reset(input string name);
        expect_ev({name, "_reset"}, 0, vec(0, 1, 0, 0, 0, 0, 0));
        reset      = 1'b1;
        pll_locked = 1'b1;
        cal_done   = 1'b0;
        #1;
        n_checks++;
        if (cur_v === vec(0, 1, 0, 0, 0, 0, 0))
            n_pass++;
        else
            $display("FAIL %s_async_reset: got vec=%b, required vec=%b",
                     name, cur_v, vec(0, 1, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_to_cal(input string name);
        expect_ev({name, "_wait_lock"}, 1,  vec(1, 1, 0, 0, 0, 0, 0));
        expect_ev({name, "_hold_st"},   6,  vec(2, 1, 0, 0, 0, 0, 0));
        expect_ev({name, "_sys_rel"},   7,  vec(2, 0, 0, 0, 0, 0, 0));
        expect_ev({name, "_cke_st"},    14, vec(3, 0, 0, 0, 0, 0, 0));
        expect_ev({name, "_rst_n_hi"},  15, vec(3, 0, 1, 0, 0, 0, 0));
        expect_ev({name, "_cal_st"},    24, vec(4, 0, 1, 0, 0, 0, 0));
        expect_ev({name, "_cke_hi"},    25, vec(4, 0, 1, 1, 1, 0, 0));
    endtask

    initial begin : stimulus
        // Nominal sequence, then lock loss while READY
        do_reset("nom");
        push_to_cal("nom");
        expect_ev("nom_ready_st", 30, vec(5, 0, 1, 1, 1, 0, 0));
        expect_ev("nom_ready_hi", 31, vec(5, 0, 1, 1, 0, 1, 0));
        wait_to(29);
        cal_done = 1'b1;
        wait_to(33);
`ifdef LOCK_LOSS_RESTART_EN
        expect_ev("lockloss_st",   36, vec(1, 0, 1, 1, 0, 1, 0));
        expect_ev("lockloss_outs", 37, vec(1, 1, 0, 0, 0, 0, 0));
`endif
        pll_locked = 1'b0;
        wait_to(45);
        drain_check("nominal");

        // Reset asserted mid WAIT_CKE, then a full re-run
        do_reset("mid");
        expect_ev("mid_wait_lock", 1,  vec(1, 1, 0, 0, 0, 0, 0));
        expect_ev("mid_hold_st",   6,  vec(2, 1, 0, 0, 0, 0, 0));
        expect_ev("mid_sys_rel",   7,  vec(2, 0, 0, 0, 0, 0, 0));
        expect_ev("mid_cke_st",    14, vec(3, 0, 0, 0, 0, 0, 0));
        expect_ev("mid_rst_n_hi",  15, vec(3, 0, 1, 0, 0, 0, 0));
        wait_to(18);
        #1;
        do_reset("mid2");
        push_to_cal("rerun");
        expect_ev("rerun_ready_st", 30, vec(5, 0, 1, 1, 1, 0, 0));
        expect_ev("rerun_ready_hi", 31, vec(5, 0, 1, 1, 0, 1, 0));
        wait_to(29);
        cal_done = 1'b1;
        wait_to(40);
        drain_check("mid_reset");

        // Single-cycle lock glitch after three counted cycles
        do_reset("jit");
        expect_ev("jit_wait_lock", 1,  vec(1, 1, 0, 0, 0, 0, 0));
        expect_ev("jit_hold_st",   10, vec(2, 1, 0, 0, 0, 0, 0));
        expect_ev("jit_sys_rel",   11, vec(2, 0, 0, 0, 0, 0, 0));
        wait_to(3);
        pll_locked = 1'b0;
        wait_to(4);
        pll_locked = 1'b1;
        wait_to(14);
        drain_check("jitter");

        // Calibration timeout, FAILED must hold
        do_reset("tmo");
        push_to_cal("tmo");
        expect_ev("tmo_failed_st", 44, vec(6, 0, 1, 1, 1, 0, 0));
        expect_ev("tmo_failed_hi", 45, vec(6, 0, 1, 0, 0, 0, 1));
        wait_to(70);
        drain_check("timeout");

        // cal_done on the timeout cycle wins
        do_reset("sim");
        push_to_cal("sim");
        expect_ev("sim_ready_st", 44, vec(5, 0, 1, 1, 1, 0, 0));
        expect_ev("sim_ready_hi", 45, vec(5, 0, 1, 1, 0, 1, 0));
        wait_to(43);
        cal_done = 1'b1;
        wait_to(55);
        drain_check("simultaneous");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
